// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad column scanner with snapshot and press/release debounce
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_in,
    output logic [3:0] key_out,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held,
    output logic       multi_key
);

    localparam logic [19:0] DWELL_MAX = 20'(SCAN_DIV - 1);
    localparam logic [3:0]  DEB_LIMIT = 4'(DEBOUNCE_SCANS);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_PRESS_DEB = 2'd1;
    localparam logic [1:0] S_HELD      = 2'd2;
    localparam logic [1:0] S_REL_DEB   = 2'd3;

    logic [3:0]  r_sync1;
    logic [3:0]  r_sync2;
    logic [19:0] r_dwell;
    logic [1:0]  r_col;
    logic [15:0] r_snap;
    logic        r_eval;
    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [3:0]  r_cand;

    logic        w_last;
    logic [4:0]  w_ones;
    logic [3:0]  w_idx;
    logic        w_none;
    logic        w_single;
    logic        w_multi;
    logic [3:0]  w_code;
    logic [3:0]  w_cnt_inc;

    assign key_out = ~(4'b0001 << r_col);
    assign w_last  = (r_dwell == DWELL_MAX);

    // Rows idle high, so the synchronizer resets to "no key".
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
        end else begin
            r_sync1 <= key_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dwell <= '0;
            r_col   <= '0;
            r_snap  <= '0;
            r_eval  <= 1'b0;
        end else if (w_last) begin
            r_dwell                <= '0;
            r_col                  <= r_col + 2'd1;
            r_snap[r_col*4 +: 4]   <= ~r_sync2;
            r_eval                 <= (r_col == 2'd3);
        end else begin
            r_dwell <= r_dwell + 20'd1;
            r_eval  <= 1'b0;
        end
    end

    // Snapshot bit i holds row i[1:0] of column i[3:2].
    always_comb begin
        w_ones = '0;
        w_idx  = '0;
        for (int i = 0; i < 16; i++) begin
            if (r_snap[i]) begin
                w_ones = w_ones + 5'd1;
                w_idx  = 4'(i);
            end
        end
    end

    assign w_none    = (w_ones == 5'd0);
    assign w_single  = (w_ones == 5'd1);
    assign w_multi   = (w_ones > 5'd1);
    assign w_code    = {w_idx[1:0], w_idx[3:2]};
    assign w_cnt_inc = r_cnt + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_cand    <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
            key_held  <= 1'b0;
            multi_key <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (r_eval) begin
                multi_key <= w_multi;
                case (r_state)
                    S_IDLE: begin
                        if (w_single) begin
                            r_cand  <= w_code;
                            r_cnt   <= 4'd1;
                            r_state <= S_PRESS_DEB;
                        end
                    end
                    S_PRESS_DEB: begin
                        if (w_single && (w_code == r_cand)) begin
                            if (w_cnt_inc == DEB_LIMIT) begin
                                key_valid <= 1'b1;
                                key_code  <= r_cand;
                                key_held  <= 1'b1;
                                r_cnt     <= '0;
                                r_state   <= S_HELD;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else begin
                            r_cnt   <= '0;
                            r_state <= S_IDLE;
                        end
                    end
                    S_HELD: begin
                        if (w_none) begin
                            r_cnt   <= 4'd1;
                            r_state <= S_REL_DEB;
                        end
                    end
                    default: begin
                        if (w_none) begin
                            if (w_cnt_inc == DEB_LIMIT) begin
                                key_held <= 1'b0;
                                r_cnt    <= '0;
                                r_state  <= S_IDLE;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else begin
                            r_cnt   <= '0;
                            r_state <= S_HELD;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner with a per-scan reference model
module tb_keypad_scanner;

    localparam int SD   = 8;
    localparam int D    = 3;
    localparam int SCAN = 4 * SD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_in;
    logic [3:0] key_out;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;
    logic       multi_key;

    // pressed[r*4+c] : key at row r, column c is closed
    logic [15:0] pressed = '0;

    typedef struct {
        logic       valid;
        logic [3:0] code;
        logic       held;
        logic       multi;
    } exp_t;

    exp_t q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;

    int         streak = 0;
    int         rel    = 0;
    logic [3:0] cand   = '0;
    logic [3:0] m_code = '0;
    bit         m_held = 0;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_out   (key_out),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held),
        .multi_key (multi_key)
    );

    always #5 clk = ~clk;

    always_comb begin
        key_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !key_out[c]) key_in[r] = 1'b0;
    end

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Edge k after reset release: column floor(k/SD)%4; scan s is evaluated at edge SCAN*(s+1)+1.
    always @(negedge clk) begin
        logic [3:0] eo;
        exp_t e;
        eo = ~(4'b0001 << ((cyc / SD) % 4));
        chk("key_out", key_out, eo);
        if (cyc >= SCAN + 1 && (cyc - 1) % SCAN == 0) begin
            if (q.size() == 0) begin
                chk("expectation_available", 4'd0, 4'd1);
            end else begin
                e = q.pop_front();
                chk("key_valid", {3'b0, key_valid}, {3'b0, e.valid});
                chk("key_code", key_code, e.code);
                chk("key_held", {3'b0, key_held}, {3'b0, e.held});
                chk("multi_key", {3'b0, multi_key}, {3'b0, e.multi});
            end
        end else if (key_valid) begin
            chk("key_valid_off_eval", {3'b0, key_valid}, 4'd0);
        end
    end

    task automatic model_scan(input logic [15:0] m);
        exp_t       e;
        int         n;
        logic [3:0] k;
        n = $countones(m);
        k = '0;
        for (int i = 0; i < 16; i++) if (m[i]) k = 4'(i);
        e.valid = 1'b0;
        if (!m_held) begin
            if (streak == 0) begin
                if (n == 1) begin
                    cand   = k;
                    streak = 1;
                end
            end else if (n == 1 && k == cand) begin
                streak++;
                if (streak == D) begin
                    e.valid = 1'b1;
                    m_held  = 1;
                    m_code  = cand;
                    streak  = 0;
                end
            end else begin
                streak = 0;
            end
        end else begin
            if (rel == 0) begin
                if (n == 0) rel = 1;
            end else if (n == 0) begin
                rel++;
                if (rel == D) begin
                    m_held = 0;
                    rel    = 0;
                end
            end else begin
                rel = 0;
            end
        end
        e.code  = m_code;
        e.held  = m_held;
        e.multi = (n > 1);
        q.push_back(e);
    endtask

    task automatic scan(input logic [15:0] m, input int n);
        repeat (n) begin
            pressed = m;
            model_scan(m);
            repeat (SCAN) @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_key_out", key_out, 4'b1110);
        chk("rst_key_valid", {3'b0, key_valid}, 4'd0);
        chk("rst_key_code", key_code, 4'h0);
        chk("rst_key_held", {3'b0, key_held}, 4'd0);
        chk("rst_multi_key", {3'b0, multi_key}, 4'd0);
        q.delete();
        streak = 0;
        rel    = 0;
        cand   = '0;
        m_code = '0;
        m_held = 0;
        repeat (n - 1) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] key(input int r, input int c);
        logic [15:0] m;
        m = '0;
        m[r*4+c] = 1'b1;
        return m;
    endfunction

    initial begin
        logic [15:0] m;
        int          b1, b2, sel;

        do_reset(3);
        scan('0, 10);

        scan(key(2, 1), 5);
        scan('0, 5);

        scan(key(0, 3), 2);
        scan('0, 1);
        scan(key(0, 3), 4);
        scan('0, 4);

        scan(key(1, 0) | key(3, 2), 6);
        scan('0, 2);

        scan(key(1, 1), 4);
        scan(key(1, 1) | key(2, 2), 4);
        scan(key(1, 1), 1);
        scan('0, 4);

        scan(key(3, 3), 2);
        tick();
        do_reset(1);
        scan(key(3, 3), 4);
        tick();
        do_reset(1);
        scan(key(3, 3), 4);
        scan('0, 4);

        m = '0;
        repeat (60) begin
            sel = int'($urandom_range(0, 9));
            if (sel >= 4 && sel <= 6) begin
                m = '0;
            end else if (sel >= 7 && sel <= 8) begin
                m = '0;
                m[$urandom_range(0, 15)] = 1'b1;
            end else if (sel == 9) begin
                b1 = int'($urandom_range(0, 15));
                b2 = (b1 + 1 + int'($urandom_range(0, 14))) % 16;
                m = '0;
                m[b1] = 1'b1;
                m[b2] = 1'b1;
            end
            scan(m, 1);
        end

        scan('0, 2);
        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", 4'(q.size()), 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Input-side counterpart of the 7-segment display path: drives the column lines of the 4x4 matrix keypad, samples the row lines, and turns raw contact closures into clean, debounced one-cycle key events for the calculator core. It owns `key_out` and `key_in` outright, so the top level no longer toggles columns by hand. The block is a free-running column scanner, a 16-bit per-scan snapshot, and a press/release debounce FSM.

## Interface

Parameters:
- `SCAN_DIV`, default 100000: clocks each column is driven; legal range 4..2^20-1.
- `DEBOUNCE_SCANS`, default 4: number of consecutive identical full scans needed to accept a press or a release; legal range 2..15.

Ports:
- `clk`, input, 1: system clock; everything is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `key_in`, input, 4: row lines, active-low (pulled up); asynchronous to `clk`.
- `key_out`, output, 4: column drive, one-cold; bit c low drives column c.
- `key_valid`, output, 1: one-cycle pulse when a debounced press is accepted.
- `key_code`, output, 4: `{row[1:0], col[1:0]}` of the last accepted key; held until the next accept.
- `key_held`, output, 1: high from the accept until the debounced release.
- `multi_key`, output, 1: high when the latest completed scan saw more than one key pressed.

## Operation

- `key_in` passes through a 2-flop synchronizer before any use.
- **Scan counter:**
  - `dwell` counts 0..SCAN_DIV-1 and `col` counts 0..3.
  - `key_out = ~(4'b0001 << col)`.
  - When `dwell` wraps to 0, `col` advances and wraps 3 to 0.
- **Sample:**
  - On the cycle with `dwell == SCAN_DIV-1`, the inverted synchronized rows are written into snapshot bits `[col*4 +: 4]`.
  - Bit index = `row + 4*col`.
- **Evaluate:**
  - Runs on the edge after the column-3 sample.
  - It classifies the snapshot as NONE (0 bits set), SINGLE (exactly 1 bit set, giving code K = `{row, col}`), or MULTI (more than 1 bit set).
  - `multi_key` is set to (class == MULTI) at every evaluation.
- **FSM states** (transitions happen only at an evaluate edge):
  - **IDLE:**
    - SINGLE K: cand = K, cnt = 1, go to PRESS_DEB.
    - NONE or MULTI: stay in IDLE.
  - **PRESS_DEB:**
    - SINGLE == cand: cnt++. If the new cnt equals DEBOUNCE_SCANS, pulse `key_valid`, set `key_code` = cand, set `key_held` = 1, cnt = 0, go to HELD.
    - Any other class or code: cnt = 0, go to IDLE (no event).
  - **HELD:**
    - NONE: cnt = 1, go to RELEASE_DEB.
    - SINGLE (any code) or MULTI: stay in HELD. No new event; a second key pressed while held is ignored.
  - **RELEASE_DEB:**
    - NONE: cnt++. If the new cnt equals DEBOUNCE_SCANS, set `key_held` = 0, cnt = 0, go to IDLE.
    - Any press: cnt = 0, go back to HELD (bounce on release; no new event).
- The snapshot is fully overwritten every scan; stale bits never persist.

## Timing

- **Reset values:**
  - `key_out` = 4'b1110 (column 0), `dwell` = 0, `col` = 0, snapshot = 0.
  - `key_valid` = 0, `key_code` = 4'h0, `key_held` = 0, `multi_key` = 0.
  - FSM in IDLE, cnt = 0.
- **Reset mid-debounce or while held:** all of the above on the next edge; no `key_valid` and no release event.
- **Full scan period** = 4*SCAN_DIV clocks. The first evaluate edge after reset is at clock 4*SCAN_DIV.
- **Output latency:** `key_valid`, `key_held`, `key_code` and `multi_key` are registered and change on the evaluate edge.
  - `key_valid` is high for exactly one clock.
  - A press stable from before scan n is accepted at the evaluate edge of scan n+DEBOUNCE_SCANS-1.
- **Synchronizer latency:** 2 clocks, always hidden by SCAN_DIV ≥ 4. The row value sampled is the value present at least SCAN_DIV-2 clocks after the column switched.
- **Back-to-back presses** need at least DEBOUNCE_SCANS NONE scans in between, so the minimum spacing of `key_valid` pulses is 2*DEBOUNCE_SCANS scans.
- **Wrap-around:** the scan counter runs forever and is never stalled by the FSM.

## Test plan

All tests use SCAN_DIV=8 and DEBOUNCE_SCANS=3, so one scan is 32 clocks. A keypad model pulls `key_in[r]` low whenever `key_out[c]` is low and key (r, c) is pressed.

- **Reset:** hold `rst` 3 clocks, release, no key pressed. Required: `key_out` = 4'b1110, then steps 1101, 1011, 0111 every 8 clocks; all other outputs stay 0 for 10 scans.
- **Clean press:** hold key row 2, col 1 from clock 0. Required: exactly one `key_valid` pulse, at evaluate edge of scan 3; `key_code` = 4'b1001; `key_held` = 1 from then. Release it; `key_held` falls at the 3rd consecutive NONE evaluation; no further pulse.
- **Bounce:** press key (0,3), drop it for one scan after 2 scans, then hold. Required: no pulse until 3 consecutive SINGLE scans after the drop; a single pulse with `key_code` = 4'b0011.
- **Multi-key:** press (1,0) and (3,2) together for 6 scans. Required: `multi_key` = 1 from the first evaluate edge, `key_valid` never asserts, `multi_key` = 0 one scan after release.
- **Held plus second key:** accept (1,1), then add (2,2) for 4 scans. Required: `multi_key` = 1, `key_held` stays 1, no new `key_valid`, `key_code` stays 4'b0101.
- **Reset mid-operation:** assert `rst` during PRESS_DEB (after 2 matching scans) and separately during HELD. Required: all outputs at reset values next clock. With the key still held, a fresh pulse arrives 3 scans after reset release.
